uart_rx_top: RTL and testbench

//  Memory-mapped UART receive path, the counterpart of the CPU-to-serial transmit path.

---
 rtl/uart_rx_top.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_top.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_top.sv
// uart_rx_top: serial receiver packing bytes MSB-first into 32-bit FIFO words.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity error bit.
module uart_rx_top #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_AW      = 4,
  parameter logic [31:0] RX_ADDR      = 32'h0000_7004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        re,
  input  logic [31:0] address,
  output logic [31:0] data_out,
  output logic        rx_empty,
  output logic        rx_full,
  output logic        frame_err
);
  localparam int CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic [31:0] ST_ADDR = RX_ADDR + 32'd4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [1:0]      k_q;
  logic [31:0]     word_q;
  logic            push_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            par_ok;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q;
  logic            parity_err_q;
  assign par_ok = !par_bad_q;
`else
  assign par_ok = 1'b1;
`endif

  logic [FIFO_AW:0] wptr_q, rptr_q;
  logic [31:0]      mem_q [DEPTH];
  logic             rd_data, rd_stat, pop, do_drop, do_push;

  assign rx_empty = (wptr_q == rptr_q);
  assign rx_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign rd_data  = re && (address == RX_ADDR);
  assign rd_stat  = re && (address == ST_ADDR);
  assign pop      = rd_data && !rx_empty;
  // A pop in the push cycle frees the slot, so the push still lands.
  assign do_drop  = push_q && rx_full && !pop;
  assign do_push  = push_q && !do_drop;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      k_q         <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (rd_stat) begin
        frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      unique case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            if (rx_sync_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              cnt_q   <= '0;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_END) begin
            cnt_q     <= '0;
            state_q   <= STOP;
            par_bad_q <= ^{shift_q, rx_sync_q};
            if (^{shift_q, rx_sync_q}) parity_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rx_sync_q) begin
              frame_err_q <= 1'b1;
            end else if (par_ok) begin
              unique case (k_q)
                2'd0: word_q[31:24] <= shift_q;
                2'd1: word_q[23:16] <= shift_q;
                2'd2: word_q[15:8]  <= shift_q;
                2'd3: word_q[7:0]   <= shift_q;
                default: ;
              endcase
              k_q <= k_q + 2'd1;
              if (k_q == 2'd3) push_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
      if (rd_stat) overrun_q <= 1'b0;
      if (do_drop) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[FIFO_AW-1:0]] <= word_q;
  end

  logic [31:0] status;
  always_comb begin
    status    = '0;
    status[0] = !rx_empty;
    status[1] = rx_full;
    status[2] = frame_err_q;
    status[3] = overrun_q;
`ifdef UART_RX_PARITY_EN
    status[4] = parity_err_q;
`endif
  end

  always_comb begin
    data_out = '0;
    if (pop)          data_out = mem_q[rptr_q[FIFO_AW-1:0]];
    else if (rd_stat) data_out = status;
  end
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: vector table, corner sequences and randomized bytes
// checked against a queue-based model of the receive path.
module tb_uart_rx_top;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA = 32'h0000_7004;
  localparam logic [31:0] A_STAT = 32'h0000_7008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        re = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_out;
  logic        rx_empty, rx_full, frame_err;

  uart_rx_top #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(4),
    .RX_ADDR(A_DATA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .re(re),
    .address(address),
    .data_out(data_out),
    .rx_empty(rx_empty),
    .rx_full(rx_full),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] m_q [$];
  logic [7:0]  m_part [$];
  bit          m_ovr, m_ferr, m_perr;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [4];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_part.delete();
    m_ovr  = 0;
    m_ferr = 0;
    m_perr = 0;
  endtask

  task automatic m_byte(logic [7:0] b, bit stop_ok, bit par_ok);
    logic [31:0] w;
    if (!stop_ok) m_ferr = 1;
    if (!par_ok) m_perr = 1;
    if (!stop_ok || !par_ok) return;
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      w = {m_part[0], m_part[1], m_part[2], m_part[3]};
      m_part.delete();
      if (m_q.size() == DEPTH) m_ovr = 1;
      else m_q.push_back(w);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (m_q.size() != 0);
    s[1] = (m_q.size() == DEPTH);
    s[2] = m_ferr;
    s[3] = m_ovr;
`ifdef UART_RX_PARITY_EN
    s[4] = m_perr;
`endif
    return s;
  endfunction

  task automatic send_byte(logic [7:0] b, bit stop_ok = 1, bit par_ok = 1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ !par_ok;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    m_byte(b, stop_ok, par_ok);
`else
    m_byte(b, stop_ok, 1'b1);
`endif
  endtask

  task automatic send_word(logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic bus_read(logic [31:0] a, output logic [31:0] d);
    address = a;
    re = 1'b1;
    #1 d = data_out;
    @(negedge clk);
    re = 1'b0;
    address = '0;
  endtask

  task automatic pop_check(string nm);
    logic [31:0] d, e;
    e = (m_q.size() != 0) ? m_q[0] : 32'h0;
    bus_read(A_DATA, d);
    if (m_q.size() != 0) void'(m_q.pop_front());
    check(nm, d, e);
  endtask

  task automatic stat_check(string nm);
    logic [31:0] d, e;
    e = m_status();
    bus_read(A_STAT, d);
    m_ovr  = 0;
    m_ferr = 0;
    m_perr = 0;
    check(nm, d, e);
  endtask

  initial begin
    logic [31:0] d;
    vecs[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEAD_BEEF};
    vecs[1] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 32'h00FF_55AA};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'h8001_7FFE};
    vecs[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678};
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_full", 32'(rx_full), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_dout", data_out, 32'h0);
    bus_read(A_STAT, d);
    check("rst_status", d, 32'h0);

    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      send_byte(vecs[i].b3);
      check("vec_nonempty", 32'(rx_empty), 32'd0);
      bus_read(A_DATA, d);
      void'(m_q.pop_front());
      check("vec_word", d, vecs[i].exp);
      check("vec_empty", 32'(rx_empty), 32'd1);
    end

    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_empty", 32'(rx_empty), 32'd1);
    send_word(32'hA1B2_C3D4);
    bus_read(A_DATA, d);
    void'(m_q.pop_front());
    check("glitch_word", d, 32'hA1B2_C3D4);

    send_byte(8'h5A, 0);
    check("ferr_pin", 32'(frame_err), 32'd1);
    bus_read(A_STAT, d);
    check("ferr_stat1", d, 32'h4);
    check("ferr_empty", 32'(rx_empty), 32'd1);
    bus_read(A_STAT, d);
    check("ferr_stat2", d, 32'h0);
    check("ferr_clr", 32'(frame_err), 32'd0);
    m_ferr = 0;

    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03, 0);
    send_byte(8'h03);
    send_byte(8'h04);
    bus_read(A_DATA, d);
    void'(m_q.pop_front());
    check("ferr_skip_word", d, 32'h0102_0304);
    stat_check("ferr_skip_stat");

    for (int i = 0; i < 17; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      send_word({iv, iv ^ 8'h55, ~iv, 8'hC3});
    end
    check("ovf_full", 32'(rx_full), 32'd1);
    bus_read(A_STAT, d);
    check("ovf_stat", d, 32'hB);
    m_ovr = 0;
    for (int i = 0; i < 16; i++) pop_check("ovf_pop");
    check("ovf_empty", 32'(rx_empty), 32'd1);
    bus_read(A_DATA, d);
    check("empty_pop", d, 32'h0);
    check("empty_pop_side", 32'(rx_empty), 32'd1);

    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    send_word(32'h1122_3344);
    check("rstmid_nonempty", 32'(rx_empty), 32'd0);
    bus_read(A_DATA, d);
    void'(m_q.pop_front());
    check("rstmid_word", d, 32'h1122_3344);
    check("rstmid_empty", 32'(rx_empty), 32'd1);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h01, 1, 0);
    bus_read(A_STAT, d);
    check("par_bad_stat", d, 32'h10);
    m_perr = 0;
    send_word(32'h0102_0304);
    pop_check("par_good_word");
`endif

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit sok, pok;
      b   = 8'($urandom);
      sok = ($urandom_range(0, 9) != 0);
      pok = ($urandom_range(0, 9) != 0);
      send_byte(b, sok, pok);
      if ($urandom_range(0, 3) == 0) pop_check("rnd_pop");
      if ($urandom_range(0, 7) == 0) stat_check("rnd_stat");
    end
    while (m_q.size() != 0) pop_check("rnd_drain");
    pop_check("rnd_drain_empty");
    stat_check("rnd_final_stat");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
